// File: rtl/ps2_keymap_engine.sv
// PS/2 key event to held-button mapper: event FIFO plus runtime-loadable key table resolved by sequential scan.
// Optional autofire gating is built when PS2_KEYMAP_AUTOFIRE_EN is defined.
module ps2_keymap_engine #(
    parameter int NUM_ENTRIES = 32,
    parameter int NUM_BTN     = 32,
    parameter int FIFO_DEPTH  = 4
`ifdef PS2_KEYMAP_AUTOFIRE_EN
    ,
    parameter int AF_HALF     = 65536
`endif
) (
    input  logic                                             clk_sys,
    input  logic                                             reset,
    input  logic [10:0]                                      ps2_key,
    input  logic                                             map_we,
    input  logic [$clog2(NUM_ENTRIES)-1:0]                   map_addr,
    input  logic                                             map_valid,
    input  logic                                             map_anyext,
    input  logic [8:0]                                       map_key,
    input  logic [((NUM_BTN > 1) ? $clog2(NUM_BTN) : 1)-1:0] map_btn,
    input  logic                                             clear_all,
`ifdef PS2_KEYMAP_AUTOFIRE_EN
    input  logic [NUM_BTN-1:0]                               autofire_mask,
`endif
    output logic [NUM_BTN-1:0]                               buttons,
    output logic                                             busy,
    output logic                                             event_drop
);

    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int BW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic            cur_pressed;
    logic [8:0]      cur_key;
    logic [NUM_BTN-1:0] held;

    logic            old_toggle;
    logic [9:0]      fifo_mem [FIFO_DEPTH];
    logic [FW-1:0]   wr_ptr;
    logic [FW-1:0]   rd_ptr;
    logic [FW:0]     count;

    logic            tbl_valid  [NUM_ENTRIES];
    logic            tbl_anyext [NUM_ENTRIES];
    logic [8:0]      tbl_key    [NUM_ENTRIES];
    logic [BW-1:0]   tbl_btn    [NUM_ENTRIES];

    logic push_req, push_ok, pop, full, fifo_ne, hit, btn_ok;

    assign push_req = ps2_key[10] != old_toggle;
    assign fifo_ne  = count != '0;
    assign full     = count == (FW+1)'(FIFO_DEPTH);
    assign pop      = (state == IDLE) && fifo_ne;
    // A full FIFO still accepts a push when the same cycle pops.
    assign push_ok  = push_req && (!full || pop);
    assign hit      = tbl_valid[idx] && (tbl_key[idx][7:0] == cur_key[7:0]) &&
                      (tbl_anyext[idx] || (tbl_key[idx][8] == cur_key[8]));
    assign btn_ok   = int'(tbl_btn[idx]) < NUM_BTN;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_toggle <= ps2_key[10];
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            event_drop <= 1'b0;
        end else begin
            old_toggle <= ps2_key[10];
            event_drop <= push_req && !push_ok;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= ps2_key[9:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FW+1)'(push_ok) - (FW+1)'(pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                tbl_valid[i] <= 1'b0;
        end else if (map_we) begin
            tbl_valid[map_addr]  <= map_valid;
            tbl_anyext[map_addr] <= map_anyext;
            tbl_key[map_addr]    <= map_key;
            tbl_btn[map_addr]    <= map_btn;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cur_pressed <= 1'b0;
            cur_key     <= '0;
            held        <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_pressed <= fifo_mem[rd_ptr][9];
                        cur_key     <= fifo_mem[rd_ptr][8:0];
                        idx         <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit && btn_ok)
                        held[tbl_btn[idx]] <= cur_pressed;
                    if (idx == AW'(NUM_ENTRIES - 1))
                        state <= IDLE;
                    else
                        idx <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
            // Placed last so a force-release overrides a same-cycle scan update.
            if (clear_all)
                held <= '0;
            busy <= (state == SCAN) || fifo_ne;
        end
    end

`ifdef PS2_KEYMAP_AUTOFIRE_EN
    logic [31:0] af_cnt;
    logic        af_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == 32'(AF_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 32'd1;
        end
    end

    assign buttons = held & ~(autofire_mask & {NUM_BTN{af_phase}});
`else
    assign buttons = held;
`endif

endmodule

// File: tb/tb_ps2_keymap_engine.sv
// Directed self-checking bench for ps2_keymap_engine (default 32 entries, 32 buttons, 4-deep FIFO).
module tb_ps2_keymap_engine;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        map_we;
    logic [4:0]  map_addr;
    logic        map_valid;
    logic        map_anyext;
    logic [8:0]  map_key;
    logic [4:0]  map_btn;
    logic        clear_all;
    logic [31:0] af_mask;
    logic [31:0] buttons;
    logic        busy;
    logic        event_drop;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_cnt = 0;

    always #5 clk_sys = ~clk_sys;

`ifdef PS2_KEYMAP_AUTOFIRE_EN
    ps2_keymap_engine #(.NUM_ENTRIES(32), .NUM_BTN(32), .FIFO_DEPTH(4), .AF_HALF(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .map_we(map_we),
        .map_addr(map_addr), .map_valid(map_valid), .map_anyext(map_anyext),
        .map_key(map_key), .map_btn(map_btn), .clear_all(clear_all),
        .autofire_mask(af_mask), .buttons(buttons), .busy(busy), .event_drop(event_drop));
`else
    ps2_keymap_engine #(.NUM_ENTRIES(32), .NUM_BTN(32), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .map_we(map_we),
        .map_addr(map_addr), .map_valid(map_valid), .map_anyext(map_anyext),
        .map_key(map_key), .map_btn(map_btn), .clear_all(clear_all),
        .buttons(buttons), .busy(busy), .event_drop(event_drop));
`endif

    always @(negedge clk_sys)
        if (event_drop === 1'b1) drop_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic pressed, input logic [8:0] key);
        ps2_key = {~ps2_key[10], pressed, key};
    endtask

    task automatic write_map(input logic [4:0] a, input logic v, input logic ax,
                             input logic [8:0] k, input logic [4:0] b);
        map_addr = a; map_valid = v; map_anyext = ax; map_key = k; map_btn = b;
        map_we = 1'b1;
        tick(1);
        map_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;
        int ones;
        reset = 1'b1; ps2_key = 11'h400; map_we = 1'b0; map_addr = '0; map_valid = 1'b0;
        map_anyext = 1'b0; map_key = '0; map_btn = '0; clear_all = 1'b0;
        af_mask = 32'h0000_0004;
        tick(3);
        reset = 1'b0;
        tick(3);
        chk("reset_buttons", buttons, 32'h0);
        chk("reset_busy", busy, 0);
        chk("reset_drop", event_drop, 0);

        // Basic press / release on entry 0.
        write_map(5'd0, 1'b1, 1'b0, 9'h029, 5'd4);
        send(1'b1, 9'h029);
        tick(2);
        chk("press_before_e2", buttons[4], 0);
        chk("busy_during_scan", busy, 1);
        tick(1);
        chk("press_after_e2", buttons[4], 1);
        tick(40);
        chk("busy_idle", busy, 0);
        send(1'b0, 9'h029);
        tick(3);
        chk("release_after_e2", buttons[4], 0);
        tick(40);
        send(1'b1, 9'h129);
        tick(40);
        chk("ext_mismatch", buttons, 32'h0);

        // anyext entry at index 3.
        write_map(5'd3, 1'b1, 1'b1, 9'h014, 5'd4);
        send(1'b1, 9'h014);
        tick(5);
        chk("anyext_before_e5", buttons[4], 0);
        tick(1);
        chk("anyext_after_e5", buttons[4], 1);
        tick(40);
        send(1'b0, 9'h114);
        tick(6);
        chk("anyext_ext_release", buttons[4], 0);
        tick(40);
        send(1'b1, 9'h114);
        tick(6);
        chk("anyext_ext_press", buttons[4], 1);
        tick(40);
        send(1'b0, 9'h029);
        tick(3);
        chk("last_event_wins", buttons[4], 0);
        tick(40);

        // Table write lands mid-scan, before entry 9 is evaluated.
        send(1'b1, 9'h01C);
        tick(5);
        write_map(5'd9, 1'b1, 1'b0, 9'h01C, 5'd6);
        tick(5);
        chk("midscan_write_before", buttons[6], 0);
        tick(1);
        chk("midscan_write_after", buttons[6], 1);
        tick(40);

        // Burst of five events while a scan is running.
        write_map(5'd10, 1'b1, 1'b0, 9'h01D, 5'd10);
        write_map(5'd11, 1'b1, 1'b0, 9'h01E, 5'd11);
        write_map(5'd12, 1'b1, 1'b0, 9'h01F, 5'd12);
        write_map(5'd13, 1'b1, 1'b0, 9'h020, 5'd13);
        base = drop_cnt;
        send(1'b1, 9'h029);
        tick(3);
        send(1'b1, 9'h01D); tick(1);
        send(1'b1, 9'h01E); tick(1);
        send(1'b1, 9'h01F); tick(1);
        send(1'b0, 9'h01D); tick(1);
        send(1'b1, 9'h020); tick(1);
        chk("burst_busy", busy, 1);
        c = 0;
        while (busy && c < 500) begin
            tick(1);
            c++;
        end
        chk("burst_busy_cycles", c, 159);
        chk("burst_drop_pulses", drop_cnt - base, 1);
        chk("burst_btn13_10", {28'h0, buttons[13:10]}, 32'h6);
        chk("burst_btn4", buttons[4], 1);

        // clear_all coinciding with the scan of entry 5.
        write_map(5'd5, 1'b1, 1'b0, 9'h033, 5'd7);
        send(1'b1, 9'h033);
        tick(7);
        chk("clear_pre", buttons[7], 0);
        clear_all = 1'b1;
        tick(1);
        clear_all = 1'b0;
        chk("clear_priority", buttons, 32'h0);
        tick(40);
        chk("clear_after_scan", buttons[7], 0);
        chk("clear_busy_idle", busy, 0);

        // Button 2 held: autofire gating or steady.
        write_map(5'd1, 1'b1, 1'b0, 9'h012, 5'd2);
        send(1'b1, 9'h012);
        tick(40);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if (buttons[2] === 1'b1) ones++;
            tick(1);
        end
`ifdef PS2_KEYMAP_AUTOFIRE_EN
        chk("autofire_duty", ones, 16);
`else
        chk("no_autofire_steady", ones, 32);
`endif

        // Reset mid-scan with a queued event.
        send(1'b1, 9'h029);
        tick(1);
        send(1'b1, 9'h01E);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(40);
        chk("reset_abort_buttons", buttons, 32'h0);
        chk("reset_abort_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keymap_engine.md
Name: ps2_keymap_engine

Overview:
- Generalised PS/2 keyboard-to-button mapper for arcade cores.
- Replaces hard-coded per-core key decode with a runtime-loadable table of NUM_ENTRIES (key -> button index) entries driving a NUM_BTN-wide held-button vector.
- Buffers key events in a small FIFO and resolves each one with a sequential table scan.
- Sits between hps_io ps2_key and the core's player/coin/start inputs.

Parameters:
- NUM_ENTRIES, 32: number of map table entries; power of two, ≥2.
- NUM_BTN, 32: width of the button vector; ≥1.
- FIFO_DEPTH, 4: depth of the event FIFO; power of two, ≥2.
- Derived (not parameters): AW = clog2(NUM_ENTRIES), BW = clog2(NUM_BTN) (minimum 1).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  bit 10 = event toggle, bit 9 = pressed, bit 8 = extended, bits 7:0 = scancode.
- map_we  in  1  table write strobe.
- map_addr  in  AW  entry index.
- map_valid  in  1  entry enable.
- map_anyext  in  1  1 = ignore the extended bit when matching.
- map_key  in  9  {ext, scancode}.
- map_btn  in  BW  target button index.
- clear_all  in  1  force-release all buttons.
- buttons  out  NUM_BTN  held-button vector, 1 = pressed.
- busy  out  1  high while scanning or while the FIFO is non-empty.
- event_drop  out  1  one-cycle pulse on FIFO overflow.

Behaviour:
- Reset: buttons = 0, busy = 0, event_drop = 0. FIFO empty. FSM in IDLE. All table entries invalid. old_toggle <= ps2_key[10], so no event is generated on reset release. Reset during a scan aborts the scan and discards queued events.
- Event capture, edge E0: if ps2_key[10] != old_toggle, push {ps2_key[9:0]} into the FIFO. old_toggle updates every cycle.
- FIFO full at push: event is discarded and event_drop pulses high the following cycle. A push and a pop in the same cycle when full are both legal; the push is accepted.
- FSM states: IDLE, SCAN.
  - IDLE: if FIFO non-empty, pop into cur_{pressed, key}, set idx = 0, go to SCAN.
  - SCAN: at each edge, evaluate entry idx. When idx == NUM_ENTRIES-1, go to IDLE; otherwise idx++.
- Match rule for entry i: valid AND scancode equal AND (anyext OR ext equal). On a match, buttons[btn] <= cur_pressed.
- Entries with btn ≥ NUM_BTN are ignored.
- Multiple entries may match one key, updating several buttons. Several keys may map to one button; the last event processed wins. No reference counting.
- Latency: an event pushed at E0 is popped at E1. Entry i updates at E(2+i) and is visible on buttons after that edge. Throughput is one event per NUM_ENTRIES+1 cycles.
- Table write: registered. A write at edge Ew affects comparisons from edge Ew+1, including a scan in progress.
- clear_all: buttons <= 0. Takes priority over a scan update in the same cycle. Does not flush the FIFO or abort the scan.
- busy = (state == SCAN) | FIFO non-empty, registered.

Optional Feature:
- Macro: PS2_KEYMAP_AUTOFIRE_EN.
- When defined:
  - Adds parameter AF_HALF (default 65536, cycles per half-period).
  - Adds input autofire_mask [NUM_BTN-1:0].
  - A free-running counter toggles af_phase every AF_HALF cycles; counter and phase reset to 0.
  - buttons = held & ~(autofire_mask & {NUM_BTN{af_phase}}).
  - Held state is unaffected by phase.
- When undefined: the port and parameter are absent, and buttons = held.

Test Plan:
- Reset with ps2_key[10] = 1 held -> no event generated, buttons = 0, busy = 0.
- Load entry 0 = {valid, key 9'h029, btn 4}. Toggle ps2_key with pressed = 1, code 9'h029 at E0 -> buttons[4] = 1 after E2. Release event -> buttons[4] = 0 after E2 of that event.
- Entry 3 = {valid, anyext = 1, key 9'h014, btn 4}. Events for 9'h014 and 9'h114 -> both set buttons[4], which becomes visible after E5.
- Five toggles on consecutive cycles with FIFO_DEPTH = 4 and N = 32 -> first four processed in order; one event_drop pulse; busy high until the final scan ends.
- Press mapped to btn 7, then assert clear_all on the same cycle its entry is scanned -> buttons[7] = 0.
- With PS2_KEYMAP_AUTOFIRE_EN defined, AF_HALF = 8, mask[2] = 1, button 2 held -> buttons[2] alternates 8 cycles on, 8 cycles off. With the macro undefined -> buttons[2] stays 1.
